// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU datapath.
package alu_pkg;

  // ALU opcodes (zero-extended to the opcode width at the point of use)
  localparam int unsigned OP_ADD = 32'h00;
  localparam int unsigned OP_SUB = 32'h01;
  localparam int unsigned OP_AND = 32'h02;
  localparam int unsigned OP_OR  = 32'h03;
  localparam int unsigned OP_XOR = 32'h04;
  localparam int unsigned OP_NOT = 32'h05;
  localparam int unsigned OP_SHL = 32'h06;
  localparam int unsigned OP_SHR = 32'h07;
  localparam int unsigned OP_MOV = 32'h08;
  localparam int unsigned OP_CMP = 32'h09;

  // Bit positions inside the 4-bit {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes the result and {N,Z,C,V} flags for one operation.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] y,
  output logic [NFLAGS-1:0] flags
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MSB  = DATA_W - 1;

  logic [SH_W-1:0]  shamt;
  logic [DATA_W:0]  sum_w;
  logic [DATA_W:0]  dif_w;
  logic [DATA_W:0]  shl_w;
  logic [DATA_W:0]  shr_w;
  logic             add_ovf;
  logic             sub_ovf;
  logic             carry;
  logic             ovf;

  assign shamt = b[SH_W-1:0];

  // One extra bit catches carry/borrow; for shifts it catches the last bit
  // shifted out (left: above the MSB, right: below the LSB), which is 0 when
  // the shift amount is 0.
  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;

  // Signed overflow: operands alike (add) / unlike (sub) in sign and the
  // result sign differs from A.
  assign add_ovf = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (dif_w[MSB] != a[MSB]);

  // Operation select; undefined opcodes yield 0 so flags become {0,1,0,0}
  always_comb begin
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (opcode)
      OP_W'(OP_ADD): begin
        y     = sum_w[DATA_W-1:0];
        carry = sum_w[DATA_W];
        ovf   = add_ovf;
      end
      OP_W'(OP_SUB), OP_W'(OP_CMP): begin
        y     = dif_w[DATA_W-1:0];
        carry = dif_w[DATA_W];
        ovf   = sub_ovf;
      end
      OP_W'(OP_AND): y = a & b;
      OP_W'(OP_OR):  y = a | b;
      OP_W'(OP_XOR): y = a ^ b;
      OP_W'(OP_NOT): y = ~a;
      OP_W'(OP_SHL): begin
        y     = shl_w[DATA_W-1:0];
        carry = shl_w[DATA_W];
      end
      OP_W'(OP_SHR): begin
        y     = shr_w[DATA_W:1];
        carry = shr_w[0];
      end
      OP_W'(OP_MOV): y = b;
      default:       y = '0;
    endcase
  end

  // Flags are derived from the selected result plus the op-specific C/V
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = y[MSB];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_datapath_pipe.sv
// Two-stage pipelined register-file/ALU datapath. Stage A holds the issued
// instruction; operands are read (with forwarding from stage B) when it
// advances. Stage B holds the registered result/flags and writes back at retire.
module alu_datapath_pipe
  import alu_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  NREGS  = 16,
  parameter int  OP_W   = 8,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] immediate,
  input  logic              wb_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  // Stage A (issued, not yet executed)
  logic              a_valid_q;
  logic [OP_W-1:0]   a_opcode_q;
  logic [ADDR_W-1:0] a_rs1_q;
  logic [ADDR_W-1:0] a_rs2_q;
  logic [ADDR_W-1:0] a_rd_q;
  logic              a_imm_sel_q;
  logic [DATA_W-1:0] a_imm_q;
  logic              a_wb_en_q;

  // Stage B (executed, waiting to retire)
  logic              b_valid_q;
  logic [ADDR_W-1:0] b_rd_q;
  logic              b_wr_q;      // will write rd at retire (wb_en and not CMP)
  logic [DATA_W-1:0] result_q;
  logic [3:0]        flags_q;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic              accept;
  logic              a_adv;
  logic              retire;
  logic              a_is_cmp;
  logic              b_wr_d;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_y;
  logic [3:0]        alu_flags;

  logic [ADDR_W-1:0] rd_addr  [2];
  logic              fwd_hit  [2];
  logic [DATA_W-1:0] rd_value [2];

  assign retire    = b_valid_q & out_ready;
  assign a_adv     = a_valid_q & (~b_valid_q | retire);
  assign in_ready  = ~a_valid_q | a_adv;
  assign accept    = in_valid & in_ready;
  assign a_is_cmp  = (a_opcode_q == OP_W'(OP_CMP));
  assign b_wr_d    = a_wb_en_q & ~a_is_cmp;

  assign out_valid = b_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Register-file read ports with bypass from stage B. B only holds a value
  // here when it is retiring in the same cycle, so the bypass makes the new
  // op see the value being written back.
  assign rd_addr[0] = a_rs1_q;
  assign rd_addr[1] = a_rs2_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    assign fwd_hit[gi]  = b_valid_q & b_wr_q & (b_rd_q == rd_addr[gi]);
    assign rd_value[gi] = fwd_hit[gi] ? result_q : regs_q[rd_addr[gi]];
  end

  assign op_a = rd_value[0];
  assign op_b = a_imm_sel_q ? a_imm_q : rd_value[1];

  alu_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu_core (
    .a      (op_a),
    .b      (op_b),
    .opcode (a_opcode_q),
    .y      (alu_y),
    .flags  (alu_flags)
  );

  // Stage A: capture the instruction on accept, empty it when it advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_rs1_q     <= '0;
      a_rs2_q     <= '0;
      a_rd_q      <= '0;
      a_imm_sel_q <= 1'b0;
      a_imm_q     <= '0;
      a_wb_en_q   <= 1'b0;
    end else if (accept) begin
      a_valid_q   <= 1'b1;
      a_opcode_q  <= opcode;
      a_rs1_q     <= rs1;
      a_rs2_q     <= rs2;
      a_rd_q      <= rd;
      a_imm_sel_q <= imm_sel;
      a_imm_q     <= immediate;
      a_wb_en_q   <= wb_en;
    end else if (a_adv) begin
      a_valid_q   <= 1'b0;
    end
  end

  // Stage B: register the ALU output on advance; hold it under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid_q <= 1'b0;
      b_rd_q    <= '0;
      b_wr_q    <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (a_adv) begin
      b_valid_q <= 1'b1;
      b_rd_q    <= a_rd_q;
      b_wr_q    <= b_wr_d;
      result_q  <= alu_y;
      flags_q   <= alu_flags;
    end else if (retire) begin
      b_valid_q <= 1'b0;
    end
  end

  // Register file: the only write path is retirement of stage B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (retire && b_wr_q) begin
      regs_q[b_rd_q] <= result_q;
    end
  end

endmodule

// File: tb/tb_alu_datapath_pipe.sv
// Randomised + directed bench for alu_datapath_pipe against a sequential
// architectural model (program-order register state, expected-result queue).
module tb_alu_datapath_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // 16-bit / 16-register instance
  logic        in_valid, in_ready, imm_sel, wb_en, out_valid, out_ready;
  logic [7:0]  opcode;
  logic [3:0]  rs1, rs2, rd;
  logic [15:0] immediate, result;
  logic [3:0]  flags;

  // 32-bit / 8-register instance
  logic        w_in_valid, w_in_ready, w_imm_sel, w_wb_en, w_out_valid, w_out_ready;
  logic [7:0]  w_opcode;
  logic [2:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_immediate, w_result;
  logic [3:0]  w_flags;

  alu_datapath_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm_sel(imm_sel),
    .immediate(immediate), .wb_en(wb_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  alu_datapath_pipe #(.DATA_W(32), .NREGS(8), .OP_W(8)) dut32 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opcode(w_opcode), .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .imm_sel(w_imm_sel),
    .immediate(w_immediate), .wb_en(w_wb_en), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .result(w_result), .flags(w_flags)
  );

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rs1, rs2, rd;
    logic        isel;
    logic [15:0] imm;
    logic        wb;
    bit          has_k;
    logic [15:0] kres;
    logic [3:0]  kflg;
  } op_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
    bit          has_k;
    logic [15:0] kres;
    logic [3:0]  kflg;
  } exp_t;

  op_t  pend[$];
  exp_t expq[$];
  longint unsigned mregs [16];

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    n_acc = 0;
  bit    lat_chk = 0;
  string tname = "init";

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: plain integer arithmetic, signed range test for V.
  // Returns {N,Z,C,V, result[31:0]}.
  function automatic logic [35:0] ref_alu(int op, longint unsigned a, longint unsigned b, int w);
    longint unsigned m, half, y;
    longint sa, sb, r, lo, hi;
    bit c, v;
    int s;
    m    = (64'd1 << w) - 1;
    half = 64'd1 << (w - 1);
    lo   = -longint'(half);
    hi   = longint'(half) - 1;
    sa   = (a >= half) ? longint'(a) - longint'(m) - 1 : longint'(a);
    sb   = (b >= half) ? longint'(b) - longint'(m) - 1 : longint'(b);
    s    = int'(b % longint'(w));
    c = 0; v = 0; y = 0;
    case (op)
      0: begin y = (a + b) & m; c = (a + b) > m; r = sa + sb; v = (r > hi) || (r < lo); end
      1, 9: begin y = (a - b) & m; c = a < b; r = sa - sb; v = (r > hi) || (r < lo); end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = (~a) & m;
      6: begin y = (a << s) & m; c = (s != 0) && (((a >> (w - s)) & 1) == 1); end
      7: begin y = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      8: y = b & m;
      default: y = 0;
    endcase
    return {((y >> (w - 1)) & 1) == 1, y == 0, c, v, y[31:0]};
  endfunction

  // Program-order execution: each accepted op sees all earlier ops' writes
  task automatic model_issue(op_t o);
    longint unsigned a, b;
    logic [35:0] r;
    exp_t e;
    a = mregs[o.rs1];
    b = o.isel ? longint'(o.imm) : mregs[o.rs2];
    r = ref_alu(int'(o.op), a, b, 16);
    e.res = r[15:0]; e.flg = r[35:32]; e.cyc = cyc;
    e.has_k = o.has_k; e.kres = o.kres; e.kflg = o.kflg;
    expq.push_back(e);
    if (o.wb && o.op != 8'd9) mregs[o.rd] = longint'(r[15:0]);
  endtask

  function automatic op_t mk(int op, int s1, int s2, int d, bit isel, int imm, bit wb);
    op_t o;
    o.op = 8'(op); o.rs1 = 4'(s1); o.rs2 = 4'(s2); o.rd = 4'(d);
    o.isel = isel; o.imm = 16'(imm); o.wb = wb;
    o.has_k = 0; o.kres = '0; o.kflg = '0;
    return o;
  endfunction

  function automatic op_t mkk(op_t o, int kres, int kflg);
    op_t t;
    t = o; t.has_k = 1; t.kres = 16'(kres); t.kflg = 4'(kflg);
    return t;
  endfunction

  function automatic op_t rnd_op();
    int imm;
    case ($urandom_range(0, 5))
      0: imm = 0;
      1: imm = 1;
      2: imm = 16'hFFFF;
      3: imm = 16'h8000;
      4: imm = 16'h7FFF;
      default: imm = int'($urandom_range(0, 16'hFFFF));
    endcase
    return mk(int'($urandom_range(0, 11)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), imm, $urandom_range(0, 3) != 0);
  endfunction

  task automatic retire_chk();
    exp_t e;
    if (expq.size() == 0) begin
      check_val({tname, "_spurious_retire"}, 1, 0);
    end else begin
      e = expq.pop_front();
      check_val({tname, "_result"}, result, e.res);
      check_val({tname, "_flags"}, flags, e.flg);
      if (e.has_k) begin
        check_val({tname, "_known_result"}, result, e.kres);
        check_val({tname, "_known_flags"}, flags, e.kflg);
      end
      if (lat_chk) check_val({tname, "_latency"}, cyc - e.cyc, 2);
    end
  endtask

  // One clock cycle: drive at posedge+1, observe handshakes at posedge+3
  task automatic cycle(bit ordy, bit ivld);
    op_t o;
    out_ready = ordy;
    if (ivld && pend.size() > 0) begin
      o = pend[0];
      in_valid = 1; opcode = o.op; rs1 = o.rs1; rs2 = o.rs2; rd = o.rd;
      imm_sel = o.isel; immediate = o.imm; wb_en = o.wb;
    end else begin
      in_valid = 0;
    end
    #2;
    if (out_valid && out_ready) retire_chk();
    if (in_valid && in_ready) begin
      model_issue(pend[0]);
      void'(pend.pop_front());
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(bit rnd, int budget);
    int b;
    b = budget;
    while ((pend.size() > 0 || expq.size() > 0) && b > 0) begin
      if (rnd) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      else     cycle(1, 1);
      b--;
    end
    if (pend.size() > 0 || expq.size() > 0) begin
      check_val({tname, "_drain_timeout"}, 0, 1);
      pend.delete();
      expq.delete();
    end
  endtask

  task automatic w32_op(string tag, int op, int s1, int s2, int d, bit isel,
                        logic [31:0] imm, logic [31:0] kres, logic [3:0] kflg);
    bit seen;
    w_out_ready = 1; w_in_valid = 1; w_opcode = 8'(op);
    w_rs1 = 3'(s1); w_rs2 = 3'(s2); w_rd = 3'(d); w_imm_sel = isel;
    w_immediate = imm; w_wb_en = 1;
    #2;
    check_val({tag, "_in_ready"}, w_in_ready, 1);
    @(posedge clk); #1;
    w_in_valid = 0;
    seen = 0;
    for (int t = 0; t < 8 && !seen; t++) begin
      if (w_out_valid) begin
        seen = 1;
        check_val({tag, "_result"}, w_result, kres);
        check_val({tag, "_flags"}, w_flags, kflg);
        check_val({tag, "_latency"}, t, 1);
      end
      @(posedge clk); #1;
    end
    if (!seen) check_val({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; in_valid = 0; out_ready = 1; opcode = 0; rs1 = 0; rs2 = 0; rd = 0;
    imm_sel = 0; immediate = 0; wb_en = 0;
    w_in_valid = 0; w_out_ready = 1; w_opcode = 0; w_rs1 = 0; w_rs2 = 0; w_rd = 0;
    w_imm_sel = 0; w_immediate = 0; w_wb_en = 0;
    for (int i = 0; i < 16; i++) mregs[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    tname = "reset";
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_in_ready", in_ready, 1);
    check_val("reset_result", result, 0);
    check_val("reset_flags", flags, 0);
    reset = 0;
    @(posedge clk); #1;

    // 1: MOV imm -> r3, ADD r3,r3 -> r4 back-to-back (forwarded), latency 2
    tname = "fwd";
    pend.push_back(mkk(mk(8, 0, 0, 3, 1, 16'h1234, 1), 16'h1234, 4'b0000));
    pend.push_back(mkk(mk(0, 3, 3, 4, 0, 0, 1), 16'h2468, 4'b0000));
    lat_chk = 1;
    drain(0, 50);
    lat_chk = 0;

    // 2: ADD wrap with carry, SUB signed overflow
    tname = "arith";
    pend.push_back(mkk(mk(8, 0, 0, 5, 1, 16'hFFFF, 1), 16'hFFFF, 4'b1000));
    pend.push_back(mkk(mk(0, 5, 0, 6, 1, 1, 1), 16'h0000, 4'b0110));
    pend.push_back(mkk(mk(8, 0, 0, 11, 1, 16'h8000, 1), 16'h8000, 4'b1000));
    pend.push_back(mkk(mk(1, 11, 0, 12, 1, 1, 1), 16'h7FFF, 4'b0001));
    drain(0, 50);

    // 3: backpressure: 4 cycles of out_ready=0 while offering 3 ops
    tname = "stall";
    pend.push_back(mkk(mk(8, 0, 0, 7, 1, 16'h0011, 1), 16'h0011, 4'b0000));
    pend.push_back(mkk(mk(0, 7, 0, 8, 1, 1, 1), 16'h0012, 4'b0000));
    pend.push_back(mkk(mk(0, 8, 7, 9, 0, 0, 1), 16'h0023, 4'b0000));
    begin
      int acc0;
      acc0 = n_acc;
      repeat (4) cycle(0, 1);
      #2;
      check_val("stall_accepts", n_acc - acc0, 2);
      check_val("stall_in_ready", in_ready, 0);
      check_val("stall_out_valid", out_valid, 1);
      check_val("stall_hold_result", result, 16'h0011);
      @(posedge clk); #1; cyc++;
    end
    drain(0, 50);

    // 4: CMP never writes back
    tname = "cmp";
    pend.push_back(mk(8, 0, 0, 1, 1, 5, 1));
    pend.push_back(mk(8, 0, 0, 2, 1, 7, 1));
    pend.push_back(mk(8, 0, 0, 9, 1, 16'h0055, 1));
    pend.push_back(mkk(mk(9, 1, 2, 9, 0, 0, 1), 16'hFFFE, 4'b1010));
    pend.push_back(mkk(mk(8, 0, 9, 10, 0, 0, 1), 16'h0055, 4'b0000));
    drain(0, 50);

    // Random traffic with random backpressure and issue gaps
    tname = "rand1";
    for (int i = 0; i < 300; i++) pend.push_back(rnd_op());
    drain(1, 5000);

    // 5: async reset with both stages full
    tname = "midreset";
    pend.push_back(mk(8, 0, 0, 13, 1, 16'hABCD, 1));
    pend.push_back(mk(8, 0, 0, 14, 1, 16'h1357, 1));
    repeat (3) cycle(0, 1);
    check_val("full_out_valid", out_valid, 1);
    check_val("full_in_ready", in_ready, 0);
    #2;
    reset = 1;
    #1;
    check_val("async_out_valid", out_valid, 0);
    check_val("async_flags", flags, 0);
    check_val("async_result", result, 0);
    check_val("async_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    pend.delete();
    expq.delete();
    @(posedge clk); #1; cyc++;
    tname = "postreset";
    pend.push_back(mkk(mk(8, 0, 12, 0, 0, 0, 1), 16'h0000, 4'b0100));
    pend.push_back(mkk(mk(0, 13, 14, 15, 0, 0, 1), 16'h0000, 4'b0100));
    pend.push_back(mkk(mk(3, 5, 10, 15, 0, 0, 1), 16'h0000, 4'b0100));
    drain(0, 50);

    tname = "rand2";
    for (int i = 0; i < 150; i++) pend.push_back(rnd_op());
    drain(1, 3000);

    // 6: 32-bit / 8-register instance
    w32_op("w32_mov", 8, 0, 0, 1, 1, 32'h80000001, 32'h80000001, 4'b1000);
    w32_op("w32_shl", 6, 1, 0, 2, 1, 32'd1, 32'h00000002, 4'b0010);
    w32_op("w32_movf", 8, 0, 0, 3, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000);
    w32_op("w32_addwrap", 0, 3, 0, 4, 1, 32'd1, 32'h00000000, 4'b0110);
    w32_op("w32_addreg", 0, 2, 4, 5, 0, 32'd0, 32'h00000002, 4'b0000);
    w32_op("w32_shr", 7, 1, 0, 6, 1, 32'd31, 32'h00000001, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
